// File: rtl/core_rst_seq_if.sv
// Signal bundle between the configuration block / core fabric and the core reset sequencer.
interface core_rst_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            rst_req_n;
    logic [XLEN-1:0] bootvec_in;
    logic            wdt_rst;
    logic            bus_idle;
    logic            bus_rstn;
    logic            core_rstn;
    logic [XLEN-1:0] core_bootvec;
    logic            rst_busy;
    logic [1:0]      rst_cause;

    // Environment side: raises requests, observes the staged resets.
    modport master (
        output rst_req_n, bootvec_in, wdt_rst, bus_idle,
        input  bus_rstn, core_rstn, core_bootvec, rst_busy, rst_cause
    );

    // Sequencer side.
    modport slave (
        input  rst_req_n, bootvec_in, wdt_rst, bus_idle,
        output bus_rstn, core_rstn, core_bootvec, rst_busy, rst_cause
    );
endinterface

// File: rtl/core_rst_seq.sv
// Core reset sequencer: releases the bus/interconnect reset, then the CPU core reset,
// latches the boot vector at core release and records why the core last went down.
module core_rst_seq #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned STAGGER       = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input logic          clk,
    input logic          rstn,
    core_rst_seq_if.slave seq
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_HOLD,
        ST_STAG,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STAG_LD  = 8'(STAGGER - 1);
    localparam logic [7:0] DRAIN_LD = 8'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_SW      = 2'b01;
    localparam logic [1:0] CAUSE_WDT     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic                   cnt_zero;
    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;

    logic            bus_q, bus_d;
    logic            core_q, core_d;
    logic            busy_q, busy_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] bv_q, bv_d;

    assign req_s    = sync[SYNC_STAGES-1];
    assign cnt_zero = (cnt == 8'd0);

    // Synchronize the asynchronous software reset request into clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], seq.rst_req_n};
        end
    end

    // State, wait counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_RST;
            cnt     <= '0;
            bus_q   <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b1;
            cause_q <= 2'b00;
            bv_q    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bus_q   <= bus_d;
            core_q  <= core_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
            bv_q    <= bv_d;
        end
    end

    // Next state and wait counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RST: begin
                if (req_s) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (!req_s) begin
                    state_nxt = ST_RST;
                end else if (cnt_zero) begin
                    state_nxt = ST_STAG;
                    cnt_nxt   = STAG_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_STAG: begin
                if (!req_s) begin
                    state_nxt = ST_RST;
                end else if (cnt_zero) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_RUN: begin
                if (seq.wdt_rst || !req_s) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = DRAIN_LD;
                end
            end
            ST_DRAIN: begin
                if (seq.bus_idle || cnt_zero) begin
                    state_nxt = ST_RST;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // Next values of the output flops; outputs leave the block straight from registers.
    always_comb begin
        bus_d   = bus_q;
        core_d  = core_q;
        busy_d  = busy_q;
        cause_d = cause_q;
        bv_d    = bv_q;
        case (state)
            ST_RST: begin
                bus_d  = 1'b0;
                core_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_HOLD: begin
                if (req_s && cnt_zero) begin
                    bus_d = 1'b1;
                end
            end
            ST_STAG: begin
                if (!req_s) begin
                    bus_d = 1'b0;
                end else if (cnt_zero) begin
                    bv_d   = seq.bootvec_in;
                    core_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (seq.wdt_rst) begin
                    cause_d = CAUSE_WDT;
                    core_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (!req_s) begin
                    cause_d = CAUSE_SW;
                    core_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                core_d = 1'b0;
                if (seq.bus_idle) begin
                    bus_d = 1'b0;
                end else if (cnt_zero) begin
                    bus_d   = 1'b0;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            default: begin
                bus_d  = 1'b0;
                core_d = 1'b0;
                busy_d = 1'b1;
            end
        endcase
    end

    assign seq.bus_rstn     = bus_q;
    assign seq.core_rstn    = core_q;
    assign seq.rst_busy     = busy_q;
    assign seq.rst_cause    = cause_q;
    assign seq.core_bootvec = bv_q;

endmodule
